mema_writer: RTL

MEMA_WRITER -- requirements
Module: mema_writer

---
 rtl/mema_pkg.sv | 15 +
 rtl/mema_row_packer.sv | 35 +++
 rtl/mema_writer.sv | 119 +++++++++++
 3 files changed

// File: rtl/mema_pkg.sv
// Shared dimensions and FSM encoding for the matrix-A memory writer.
package mema_pkg;
  localparam int MEMA_NO_OF_ELEMENTS_ON_COL_NOS   = 20;
  localparam int MEMA_NO_OF_ROW_BY_VECTOR_MODULES = 4;
  localparam int MEMA_ELEMENT_WIDTH               = 64;
  localparam int MEMA_ROW_WIDTH =
    MEMA_NO_OF_ROW_BY_VECTOR_MODULES * MEMA_NO_OF_ELEMENTS_ON_COL_NOS * MEMA_ELEMENT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/mema_row_packer.sv
// Shift-in row packer: after a full row the first element sits in the top slot.
// row_full marks the shift that completes a row; the element count then restarts at 0.
module mema_row_packer
  import mema_pkg::*;
#(
  parameter int ELEMENT_WIDTH = MEMA_ELEMENT_WIDTH,
  parameter int ROW_BITS      = MEMA_ROW_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     shift,
  input  logic [ELEMENT_WIDTH-1:0] din,
  output logic [ROW_BITS-1:0]      word,
  output logic                     row_full
);
  localparam int SLOTS = ROW_BITS / ELEMENT_WIDTH;
  localparam int CW    = $clog2(SLOTS + 1);

  logic [CW-1:0] count;

  assign row_full = shift && (count == CW'(SLOTS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift) begin
      word  <= {word[ROW_BITS-ELEMENT_WIDTH-1:0], din};
      count <= row_full ? '0 : count + CW'(1);
    end
  end
endmodule

// File: rtl/mema_writer.sv
// Packs an element stream into row words and writes them to the matrix-A memory.
// Optional in_last framing check is enabled by defining MEMA_WRITER_LAST_CHECK_EN.
module mema_writer
  import mema_pkg::*;
#(
  parameter int NO_OF_ELEMENTS_ON_COL_NOS   = MEMA_NO_OF_ELEMENTS_ON_COL_NOS,
  parameter int NO_OF_ROW_BY_VECTOR_MODULES = MEMA_NO_OF_ROW_BY_VECTOR_MODULES,
  parameter int ELEMENT_WIDTH               = MEMA_ELEMENT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [31:0]              base_address,
  input  logic [31:0]              no_of_rows,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ELEMENT_WIDTH-1:0] in_data,
  output logic                     mem_write_en,
  output logic [31:0]              mem_write_address,
  output logic [NO_OF_ROW_BY_VECTOR_MODULES*NO_OF_ELEMENTS_ON_COL_NOS*ELEMENT_WIDTH-1:0] mem_write_data,
  output logic                     busy,
  output logic                     done
`ifdef MEMA_WRITER_LAST_CHECK_EN
  ,
  input  logic                     in_last,
  output logic                     framing_error
`endif
);
  localparam int ROW_WIDTH = NO_OF_ROW_BY_VECTOR_MODULES * NO_OF_ELEMENTS_ON_COL_NOS * ELEMENT_WIDTH;

  state_t      state;
  logic [31:0] base_q;
  logic [31:0] rows_q;
  logic [31:0] row_idx;
  logic        accept;
  logic        row_full;
  logic        load;
  logic        last_row;

  assign in_ready = (state == ST_FILL);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_ready && in_valid;
  assign load     = (state == ST_IDLE) && start;
  assign last_row = (row_idx == rows_q - 32'd1);

  // The packer word doubles as the write data; it is stable through the write cycle.
  mema_row_packer #(
    .ELEMENT_WIDTH (ELEMENT_WIDTH),
    .ROW_BITS      (ROW_WIDTH)
  ) u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (load),
    .shift    (accept),
    .din      (in_data),
    .word     (mem_write_data),
    .row_full (row_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      base_q            <= '0;
      rows_q            <= '0;
      row_idx           <= '0;
      mem_write_en      <= 1'b0;
      mem_write_address <= '0;
      done              <= 1'b0;
    end else begin
      mem_write_en <= 1'b0;
      done         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (no_of_rows != 32'd0) begin
              base_q  <= base_address;
              rows_q  <= no_of_rows;
              row_idx <= '0;
              state   <= ST_FILL;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_FILL: begin
          if (row_full) state <= ST_WRITE;
        end
        ST_WRITE: begin
          mem_write_en      <= 1'b1;
          mem_write_address <= base_q + row_idx;
          if (last_row) begin
            state <= ST_DONE;
          end else begin
            row_idx <= row_idx + 32'd1;
            state   <= ST_FILL;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEMA_WRITER_LAST_CHECK_EN
  // in_last must be high on exactly the final element of the final row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      framing_error <= 1'b0;
    end else if (load) begin
      framing_error <= 1'b0;
    end else if (accept && (in_last != (row_full && last_row))) begin
      framing_error <= 1'b1;
    end
  end
`endif
endmodule
